// File: rtl/mtimer_multi_pkg.sv
// Shared constants and types for the multi-channel machine timer.
package mtimer_pkg;

    localparam int MAX_CMP = 4;

    // Byte offsets inside the timer window.
    localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
    localparam logic [7:0] OFF_CTRL        = 8'h08;
    localparam logic [7:0] OFF_PENDING     = 8'h0C;
    localparam logic [7:0] OFF_ENABLE      = 8'h10;
    localparam logic [7:0] OFF_SNAP_HI     = 8'h14;
    localparam logic [7:0] OFF_CMP_BASE    = 8'h20;
    localparam logic [7:0] OFF_PERIOD_BASE = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_FAULT
    } bus_state_e;

    // Offset of the low word of compare channel idx (high word is +4).
    function automatic logic [7:0] cmp_lo_off(input int idx);
        return OFF_CMP_BASE + 8'(8 * idx);
    endfunction

    // Offset of the period register of channel idx.
    function automatic logic [7:0] period_off(input int idx);
        return OFF_PERIOD_BASE + 8'(4 * idx);
    endfunction

endpackage

// File: rtl/mtimer_multi_if.sv
// MMIO access bus between the memory controller decoder and the timer.
interface mtimer_multi_if;
    logic        ce;
    logic [7:0]  addr;
    logic [31:0] datain;
    logic        memwrite;
    logic [31:0] dataout;
    logic        busy;
    logic        valid;
    logic        load_access_fault;

    modport master (
        output ce, addr, datain, memwrite,
        input  dataout, busy, valid, load_access_fault
    );

    modport slave (
        input  ce, addr, datain, memwrite,
        output dataout, busy, valid, load_access_fault
    );
endinterface

// File: rtl/mtimer_multi_cmp_channel.sv
// One compare channel: compare value, optional auto-reload period and
// a sticky pending flag. Hardware set of pending beats a same-cycle clear,
// and a software compare write beats a same-cycle auto-reload.
module mtimer_cmp_channel (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] mtime_i,
    input  logic        wr_cmp_lo_i,
    input  logic        wr_cmp_hi_i,
    input  logic        wr_period_i,
    input  logic [31:0] wdata_i,
    input  logic        w1c_i,
    output logic [63:0] cmp_o,
    output logic [31:0] period_o,
    output logic        pending_o
);

    logic [63:0] cmp_q, cmp_d;
    logic [31:0] period_q, period_d;
    logic        pending_q, pending_d;
    logic        match;

    // Match detection, auto-reload and pending update.
    always_comb begin
        match     = (mtime_i >= cmp_q);
        cmp_d     = cmp_q;
        period_d  = period_q;
        pending_d = pending_q;

        if (w1c_i) begin
            pending_d = 1'b0;
        end
        if (match) begin
            pending_d = 1'b1;
        end

        if (wr_cmp_lo_i) begin
            cmp_d[31:0] = wdata_i;
        end else if (wr_cmp_hi_i) begin
            cmp_d[63:32] = wdata_i;
        end else if (match && (period_q != 32'd0)) begin
            cmp_d = cmp_q + {32'd0, period_q};
        end

        if (wr_period_i) begin
            period_d = wdata_i;
        end
    end

    // Channel state; compare resets to all-ones so nothing fires after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_q     <= 64'hFFFF_FFFF_FFFF_FFFF;
            period_q  <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            cmp_q     <= cmp_d;
            period_q  <= period_d;
            pending_q <= pending_d;
        end
    end

    assign cmp_o     = cmp_q;
    assign period_o  = period_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/mtimer_multi.sv
// Machine timer: 64-bit prescaled mtime, NUM_CMP compare channels and a
// small MMIO access FSM. The counter and channels run regardless of bus state.
module mtimer_multi
    import mtimer_pkg::*;
#(
    parameter int NUM_CMP    = 2,
    parameter int PRESCALE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    mtimer_multi_if.slave      bus,
    output logic [NUM_CMP-1:0] irq,
    output logic               intr_timer
);

    bus_state_e              state_q, state_d;
    logic [7:0]              addr_q;
    logic [31:0]             wdata_q;
    logic                    we_q;
    logic [31:0]             dataout_q;
    logic [31:0]             rdata;
    logic [31:0]             snap_q;

    logic [63:0]             mtime_q;
    logic [PRESCALE_W-1:0]   pc_q;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic                    ctrl_en_q;
    logic [NUM_CMP-1:0]      enable_q;

    logic                    commit;
    logic                    wr_en;
    logic                    rd_en;
    logic                    ctrl_wr;
    logic                    tick;

    logic [63:0]             cmp_w    [NUM_CMP];
    logic [31:0]             period_w [NUM_CMP];
    logic [NUM_CMP-1:0]      pending_w;

    // Address decode: aligned, mapped, and SNAP_HI is read-only.
    function automatic logic addr_ok(input logic [7:0] a, input logic we);
        logic ok;
        ok = 1'b0;
        if (a[1:0] == 2'b00) begin
            case (a)
                OFF_MTIME_LO, OFF_MTIME_HI, OFF_CTRL,
                OFF_PENDING, OFF_ENABLE: ok = 1'b1;
                OFF_SNAP_HI:             ok = !we;
                default: begin
                    if (a >= OFF_CMP_BASE && a < OFF_CMP_BASE + 8'(8 * NUM_CMP)) begin
                        ok = 1'b1;
                    end
                    if (a >= OFF_PERIOD_BASE && a < OFF_PERIOD_BASE + 8'(4 * NUM_CMP)) begin
                        ok = 1'b1;
                    end
                end
            endcase
        end
        return ok;
    endfunction

    // An access commits only on the ACCESS cycle with ce still held low.
    assign commit  = (state_q == ST_ACCESS) && !bus.ce;
    assign wr_en   = commit && we_q;
    assign rd_en   = commit && !we_q;
    assign ctrl_wr = wr_en && (addr_q == OFF_CTRL);

    // Bus FSM next state and status outputs.
    always_comb begin
        state_d               = state_q;
        bus.busy              = 1'b0;
        bus.valid             = 1'b0;
        bus.load_access_fault = 1'b0;
        bus.dataout           = dataout_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.ce) begin
                    state_d = addr_ok(bus.addr, bus.memwrite) ? ST_ACCESS : ST_FAULT;
                end
            end
            ST_ACCESS: begin
                bus.busy = 1'b1;
                state_d  = bus.ce ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                bus.valid = !we_q;
                if (bus.ce) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                bus.load_access_fault = 1'b1;
                if (bus.ce) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus state, request latch, read data and the MTIME high-word snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= 8'd0;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            dataout_q <= 32'd0;
            snap_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && !bus.ce) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.datain;
                we_q    <= bus.memwrite;
            end
            if (rd_en) begin
                dataout_q <= rdata;
                if (addr_q == OFF_MTIME_LO) begin
                    snap_q <= mtime_q[63:32];
                end
            end
        end
    end

    // Read multiplexer over the register map.
    always_comb begin
        rdata = 32'd0;
        case (addr_q)
            OFF_MTIME_LO: rdata = mtime_q[31:0];
            OFF_MTIME_HI: rdata = mtime_q[63:32];
            OFF_CTRL: begin
                rdata[0]              = ctrl_en_q;
                rdata[8 +: PRESCALE_W] = prescale_q;
            end
            OFF_PENDING:  rdata[NUM_CMP-1:0] = pending_w;
            OFF_ENABLE:   rdata[NUM_CMP-1:0] = enable_q;
            OFF_SNAP_HI:  rdata = snap_q;
            default:      rdata = 32'd0;
        endcase
        for (int k = 0; k < NUM_CMP; k++) begin
            if (addr_q == cmp_lo_off(k)) begin
                rdata = cmp_w[k][31:0];
            end
            if (addr_q == cmp_lo_off(k) + 8'd4) begin
                rdata = cmp_w[k][63:32];
            end
            if (addr_q == period_off(k)) begin
                rdata = period_w[k];
            end
        end
    end

    // CTRL and ENABLE registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en_q  <= 1'b0;
            prescale_q <= '0;
            enable_q   <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en_q  <= wdata_q[0];
                prescale_q <= wdata_q[8 +: PRESCALE_W];
            end
            if (wr_en && (addr_q == OFF_ENABLE)) begin
                enable_q <= wdata_q[NUM_CMP-1:0];
            end
        end
    end

    // A CTRL write restarts the prescaler and swallows that cycle's tick.
    assign tick = ctrl_en_q && (pc_q == prescale_q) && !ctrl_wr;

    // Prescaler and mtime; a software write to either half wins over the tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            mtime_q <= 64'd0;
        end else begin
            if (ctrl_wr) begin
                pc_q <= '0;
            end else if (ctrl_en_q) begin
                pc_q <= (pc_q == prescale_q) ? '0 : pc_q + 1'b1;
            end
            if (wr_en && (addr_q == OFF_MTIME_LO)) begin
                mtime_q[31:0] <= wdata_q;
            end else if (wr_en && (addr_q == OFF_MTIME_HI)) begin
                mtime_q[63:32] <= wdata_q;
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_ch
        mtimer_cmp_channel u_ch (
            .clk         (clk),
            .reset       (reset),
            .mtime_i     (mtime_q),
            .wr_cmp_lo_i (wr_en && (addr_q == cmp_lo_off(gi))),
            .wr_cmp_hi_i (wr_en && (addr_q == cmp_lo_off(gi) + 8'd4)),
            .wr_period_i (wr_en && (addr_q == period_off(gi))),
            .wdata_i     (wdata_q),
            .w1c_i       (wr_en && (addr_q == OFF_PENDING) && wdata_q[gi]),
            .cmp_o       (cmp_w[gi]),
            .period_o    (period_w[gi]),
            .pending_o   (pending_w[gi])
        );
    end

    assign irq        = pending_w & enable_q;
    assign intr_timer = |irq;

endmodule

// File: doc/mtimer_multi.md
Name: mtimer_multi

Overview:
- Parametrised machine-timer peripheral; successor to the single mtime/mtimecmp pair inside the memory controller.
- Provides one 64-bit mtime counter with a programmable prescaler and enable.
- Provides NUM_CMP compare channels, each with optional periodic auto-reload, sticky pending bits, an enable mask and a tear-free 64-bit read snapshot.
- The memory controller's MMIO decoder drives ce low for accesses in this block's window and passes the byte offset.

Parameters:
- NUM_CMP, 2, number of compare channels (legal 1..4).
- PRESCALE_W, 8, width of the prescaler divide field.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  active-low access strobe; held low for the whole access
- addr  in  8  byte offset within block window
- datain  in  32  write data
- memwrite  in  1  1 = write, 0 = read; sampled with ce
- dataout  out  32  read data; valid while valid=1
- busy  out  1  access in progress
- valid  out  1  read data ready
- load_access_fault  out  1  unmapped/misaligned access
- irq  out  NUM_CMP  per-channel irq = pending & enable
- intr_timer  out  1  OR of irq

Behaviour:
- Reset (async, reset=0), all zero except as noted:
  - mtime, ctrl, pending, enable, period_i, snap = 0; dataout = 0.
  - cmp_i = 64'hFFFF_FFFF_FFFF_FFFF, so there is no spurious interrupt.
  - state = IDLE.
- Register map (word offsets; addr[1:0] != 0 -> FAULT):
  - 0x00 MTIME lo, 0x04 MTIME hi.
  - 0x08 CTRL: bit0 = enable, bits[8+PRESCALE_W-1:8] = prescale.
  - 0x0C PENDING (write-1-to-clear), 0x10 ENABLE.
  - 0x14 SNAP_HI, read-only; a write here faults.
  - 0x20+8i CMP_i lo, 0x24+8i CMP_i hi.
  - 0x40+4i PERIOD_i, 32-bit.
  - Any offset for i >= NUM_CMP, or an unlisted offset -> FAULT.
- Counter:
  - While ctrl.enable, a prescale counter pc counts 0..prescale. When pc == prescale, pc wraps to 0 and mtime increments (64-bit wrap to 0).
  - prescale = 0 means mtime increments every cycle.
  - enable = 0 freezes both mtime and pc.
  - A write to CTRL resets pc to 0.
- Software write to MTIME lo/hi replaces that half in that cycle; the increment is suppressed that cycle.
- Snapshot: a read of MTIME lo latches mtime[63:32] into snap in the same cycle. Software reads lo, then SNAP_HI, to get a consistent 64-bit value.
- Channel i:
  - match_i = (mtime >= cmp_i), unsigned 64-bit.
  - match_i = 1 sets pending_i.
  - If period_i != 0 and match_i: cmp_i <= cmp_i + zero-extended period_i, wrapping modulo 2^64.
  - If period_i == 0 (one-shot, level): pending_i re-sets every cycle while match persists, so W1C is ineffective until cmp is raised.
- Simultaneous events:
  - Software write to CMP_i wins over auto-reload in the same cycle.
  - Hardware set of pending_i wins over a W1C in the same cycle.
  - Writing ENABLE takes effect on irq the next cycle.
- Bus FSM states: IDLE, ACCESS, DONE, FAULT.
  - IDLE: when ce = 0, latch addr/datain/memwrite. Go to FAULT if decode fails, else to ACCESS.
  - ACCESS (busy = 1): perform the write, or load dataout. Go to DONE.
  - DONE: valid = 1 only if the access was a read; busy = 0.
  - FAULT: load_access_fault = 1, busy = 0, valid = 0.
  - DONE and FAULT hold until ce = 1, then return to IDLE.
  - ce = 1 in ACCESS aborts to IDLE without committing the write.
- Read latency: valid is asserted 2 cycles after ce falls.
- Counter and channels run independently of the bus FSM.
- Asserting reset mid-access returns the block to IDLE with all registers at reset values immediately.

Decomposition:
- Package mtimer_pkg holds:
  - register offset constants (OFF_MTIME_LO, OFF_CTRL, OFF_CMP_BASE, OFF_PERIOD_BASE, ...);
  - bus state enum;
  - MAX_CMP = 4.
- Sub-module mtimer_cmp_channel, instantiated via generate per channel:
  - holds cmp, period and pending;
  - does the match compare and auto-reload;
  - provides the software write ports and the W1C input.

Test Plan:
- Reset: after reset, intr_timer = 0 and a read of CMP_0 hi returns 0xFFFFFFFF. Read of 0x00 returns a small nonzero value only after writing CTRL = 1.
- Prescaler: write CTRL = 0x0301 (prescale 3, enable) -> mtime increments once every 4 clk. With CTRL = 0x0300 (enable = 0), mtime stays constant over 100 cycles.
- Snapshot tear: write MTIME lo = 0xFFFFFFFE, hi = 0, CTRL = 1; read lo, then SNAP_HI -> the pair is consistent (hi = 0 together with lo >= 0xFFFFFFFE, or hi = 1 together with lo < 0x10).
- One-shot: CMP_0 = 100, ENABLE = 1, CTRL = 1 -> irq[0] asserts when mtime reaches 100. A W1C of PENDING = 1 has no effect; writing CMP_0 hi = 0xFFFFFFFF and then W1C clears irq[0].
- Periodic: CMP_1 = 50, PERIOD_1 = 20, ENABLE = 2 -> pending_1 is set at mtime 50, 70 and 90. CMP_1 reads 110 after mtime passes 90. Same-cycle W1C and match leaves pending = 1.
- Faults/abort:
  - Read of 0x02, read of 0x20+8*NUM_CMP, or a write to 0x14 -> load_access_fault = 1 until ce = 1.
  - A write raising ce during ACCESS is not committed.
  - Reset asserted mid-access -> IDLE and all registers at reset values.
